// File: rtl/ps2_keys_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ps2_keys_pkg: set-2 arrow scan codes, key indices, parser states.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package ps2_keys_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  localparam logic [1:0] KEY_LEFT  = 2'd3;
  localparam logic [1:0] KEY_UP    = 2'd2;
  localparam logic [1:0] KEY_RIGHT = 2'd1;
  localparam logic [1:0] KEY_DOWN  = 2'd0;

  localparam int EVT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_e;

  typedef struct packed {
    logic [1:0] key;
    logic       make;
  } key_evt_t;

  function automatic logic is_arrow(input logic [7:0] b);
    return (b == SC_LEFT) || (b == SC_UP) || (b == SC_RIGHT) || (b == SC_DOWN);
  endfunction

  function automatic logic [1:0] arrow_key(input logic [7:0] b);
    case (b)
      SC_LEFT:  return KEY_LEFT;
      SC_UP:    return KEY_UP;
      SC_RIGHT: return KEY_RIGHT;
      default:  return KEY_DOWN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | key_event_fifo: show-ahead synchronous FIFO with full/empty flags.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module key_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  // Head reads as zero when empty so the event outputs are clean after reset.
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/arrow_key_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | arrow_key_tracker: PS/2 set-2 arrow parser, hold state, event queue.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module arrow_key_tracker
  import ps2_keys_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter bit ACCEPT_NUMPAD  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic [3:0] hold,
  output logic [3:0] press_pulse,
  output logic [3:0] release_pulse,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_key,
  output logic       evt_make,
  output logic       overflow,
  input  logic       clear_overflow
);

  localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  parse_state_e  state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    hold_q, hold_d;
  logic [3:0]    press_q, press_d;
  logic [3:0]    rel_q, rel_d;
  logic          push_q, push_d;
  key_evt_t      push_evt_q, push_evt_d;
  logic          overflow_q, overflow_d;

  logic          do_make, do_break, arrow;
  logic [1:0]    key;
  logic          fifo_full, fifo_empty, fifo_pop, fifo_drop;
  logic [EVT_W-1:0] fifo_head;
  key_evt_t      head_evt;

  assign arrow     = is_arrow(ps2_byte);
  assign key       = arrow_key(ps2_byte);
  assign fifo_pop  = !fifo_empty && evt_ready;
  assign fifo_drop = push_q && fifo_full && !fifo_pop;

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    hold_d     = hold_q;
    press_d    = '0;
    rel_d      = '0;
    push_d     = 1'b0;
    push_evt_d = push_evt_q;
    do_make    = 1'b0;
    do_break   = 1'b0;

    if (ps2_byte_valid) begin
      // A byte always restarts the idle timer, even on the expiry cycle.
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_byte == SC_E0)      state_d = ST_EXT;
          else if (ps2_byte == SC_F0) state_d = ST_BRK;
          else                        do_make = arrow && ACCEPT_NUMPAD;
        end
        ST_EXT: begin
          if (ps2_byte == SC_F0) begin
            state_d = ST_EXT_BRK;
          end else if (arrow) begin
            do_make = 1'b1;
            state_d = ST_IDLE;
          end else if (ps2_byte != SC_E0) begin
            state_d = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          do_break = arrow;
          state_d  = ST_IDLE;
        end
        ST_BRK: begin
          do_break = arrow && ACCEPT_NUMPAD;
          state_d  = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TO_LAST) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    // Typematic repeats and breaks of unheld keys produce nothing.
    if (do_make && !hold_q[key]) begin
      hold_d[key]  = 1'b1;
      press_d[key] = 1'b1;
      push_d       = 1'b1;
      push_evt_d   = '{key: key, make: 1'b1};
    end
    if (do_break && hold_q[key]) begin
      hold_d[key] = 1'b0;
      rel_d[key]  = 1'b1;
      push_d      = 1'b1;
      push_evt_d  = '{key: key, make: 1'b0};
    end

    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (fifo_drop)      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tmo_q      <= '0;
      hold_q     <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      push_q     <= 1'b0;
      push_evt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      push_q     <= push_d;
      push_evt_q <= push_evt_d;
      overflow_q <= overflow_d;
    end
  end

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_q),
    .push_data (push_evt_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_evt      = fifo_head;
  assign hold          = hold_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign evt_valid     = !fifo_empty;
  assign evt_key       = head_evt.key;
  assign evt_make      = head_evt.make;
  assign overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_arrow_key_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_arrow_key_tracker: two trackers (numpad off/on) vs. an event model. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_arrow_key_tracker;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic       evt_ready;
  logic       clear_overflow;

  logic [3:0] d_hold[2], d_press[2], d_rel[2];
  logic       d_ev_valid[2], d_ev_make[2], d_ovf[2];
  logic [1:0] d_ev_key[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arrow_key_tracker #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .ACCEPT_NUMPAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
    .hold(d_hold[0]), .press_pulse(d_press[0]), .release_pulse(d_rel[0]),
    .evt_valid(d_ev_valid[0]), .evt_ready(evt_ready), .evt_key(d_ev_key[0]),
    .evt_make(d_ev_make[0]), .overflow(d_ovf[0]), .clear_overflow(clear_overflow));

  arrow_key_tracker #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .ACCEPT_NUMPAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
    .hold(d_hold[1]), .press_pulse(d_press[1]), .release_pulse(d_rel[1]),
    .evt_valid(d_ev_valid[1]), .evt_ready(evt_ready), .evt_key(d_ev_key[1]),
    .evt_make(d_ev_make[1]), .overflow(d_ovf[1]), .clear_overflow(clear_overflow));

  // Model: index 0 ignores plain keypad codes, index 1 accepts them.
  // Parser mode: 0 none, 1 after E0, 2 after F0, 3 after E0 F0.
  logic [3:0] m_hold[2], m_press[2], m_rel[2];
  logic [2:0] m_q[2][8];
  int         m_n[2], m_mode[2], m_quiet[2];
  logic       m_pp[2], m_ovf[2];
  logic [2:0] m_pd[2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic int key_of(input logic [7:0] b);
    case (b)
      8'h6B:   return 3;
      8'h75:   return 2;
      8'h74:   return 1;
      8'h72:   return 0;
      default: return -1;
    endcase
  endfunction

  task automatic model_key(input int i, input int k, input bit make);
    if (make && !m_hold[i][k]) begin
      m_hold[i][k] = 1'b1; m_press[i][k] = 1'b1;
      m_pp[i] = 1'b1; m_pd[i] = {2'(k), 1'b1};
    end else if (!make && m_hold[i][k]) begin
      m_hold[i][k] = 1'b0; m_rel[i][k] = 1'b1;
      m_pp[i] = 1'b1; m_pd[i] = {2'(k), 1'b0};
    end
  endtask

  task automatic model_step(input int i);
    bit np;
    int k;
    np = (i == 1);
    // Queue side: pop the head, then append the event produced last cycle.
    if (m_n[i] > 0 && evt_ready) begin
      for (int j = 0; j < 7; j++) m_q[i][j] = m_q[i][j+1];
      m_n[i]--;
    end
    if (clear_overflow) m_ovf[i] = 1'b0;
    if (m_pp[i]) begin
      if (m_n[i] < DEPTH) begin
        m_q[i][m_n[i]] = m_pd[i];
        m_n[i]++;
      end else begin
        m_ovf[i] = 1'b1;
      end
    end
    m_pp[i] = 1'b0; m_press[i] = '0; m_rel[i] = '0;
    if (ps2_byte_valid) begin
      k = key_of(ps2_byte);
      m_quiet[i] = 0;
      case (m_mode[i])
        0: begin
          if (ps2_byte == 8'hE0)      m_mode[i] = 1;
          else if (ps2_byte == 8'hF0) m_mode[i] = 2;
          else if (k >= 0 && np)      model_key(i, k, 1'b1);
        end
        1: begin
          if (ps2_byte == 8'hF0)      m_mode[i] = 3;
          else if (k >= 0) begin      model_key(i, k, 1'b1); m_mode[i] = 0; end
          else if (ps2_byte != 8'hE0) m_mode[i] = 0;
        end
        2: begin
          if (k >= 0 && np) model_key(i, k, 1'b0);
          m_mode[i] = 0;
        end
        default: begin
          if (k >= 0) model_key(i, k, 1'b0);
          m_mode[i] = 0;
        end
      endcase
    end else if (m_mode[i] != 0) begin
      m_quiet[i]++;
      if (m_quiet[i] == TMO) begin
        m_mode[i] = 0;
        m_quiet[i] = 0;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_hold[i] = '0; m_press[i] = '0; m_rel[i] = '0;
        m_n[i] = 0; m_mode[i] = 0; m_quiet[i] = 0;
        m_pp[i] = 1'b0; m_pd[i] = '0; m_ovf[i] = 1'b0;
      end else begin
        model_step(i);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("hold%0d", i), d_hold[i], m_hold[i]);
      chk($sformatf("press%0d", i), d_press[i], m_press[i]);
      chk($sformatf("release%0d", i), d_rel[i], m_rel[i]);
      chk($sformatf("evt_valid%0d", i), d_ev_valid[i], m_n[i] != 0);
      chk($sformatf("overflow%0d", i), d_ovf[i], m_ovf[i]);
      if (m_n[i] != 0) begin
        chk($sformatf("evt_head%0d", i), {d_ev_key[i], d_ev_make[i]}, m_q[i][0]);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_byte = b; ps2_byte_valid = 1'b1;
    @(negedge clk);
    ps2_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ps2_byte = '0; ps2_byte_valid = 1'b0;
    evt_ready = 1'b1; clear_overflow = 1'b0;
    idle(3);
    chk("rst_hold", d_hold[1], 4'b0000);
    chk("rst_evt_valid", d_ev_valid[1], 1'b0);
    chk("rst_evt_key_make", {d_ev_key[1], d_ev_make[1]}, 3'b000);
    chk("rst_overflow", d_ovf[1], 1'b0);
    reset = 1'b0;

    // Extended up press then release.
    send(8'hE0); send(8'h75);
    chk("up_hold", d_hold[1], 4'b0100);
    chk("up_press", d_press[1], 4'b0100);
    idle(1);
    chk("up_press_gone", d_press[1], 4'b0000);
    chk("up_evt", {d_ev_valid[1], d_ev_key[1], d_ev_make[1]}, 4'b1101);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_rel_hold", d_hold[1], 4'b0000);
    chk("up_rel_pulse", d_rel[1], 4'b0100);
    idle(1);
    chk("up_rel_evt", {d_ev_valid[1], d_ev_key[1], d_ev_make[1]}, 4'b1100);

    // Simultaneous holds and typematic repeat.
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
    chk("lr_hold", d_hold[0], 4'b1010);
    for (int r = 0; r < 3; r++) begin send(8'hE0); send(8'h75); end
    chk("repeat_press", d_press[1], 4'b0000);
    chk("repeat_hold", d_hold[1], 4'b1110);

    // Break of an unheld key.
    send(8'hE0); send(8'hF0); send(8'h72);
    chk("unheld_rel", d_rel[1], 4'b0000);
    idle(4);
    chk("drained", d_ev_valid[1], 1'b0);

    // Fill the queue: five events, the fifth is dropped.
    evt_ready = 1'b0;
    send(8'hE0); send(8'hF0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); send(8'h72);
    send(8'hE0); send(8'hF0); send(8'h72);
    idle(2);
    chk("ovf_set", d_ovf[0], 1'b1);
    chk("ovf_hold", d_hold[1], 4'b0000);
    chk("ovf_head", {d_ev_valid[1], d_ev_key[1], d_ev_make[1]}, 4'b1110);
    @(negedge clk) clear_overflow = 1'b1;
    @(negedge clk) clear_overflow = 1'b0;
    chk("ovf_cleared", d_ovf[1], 1'b0);

    // Push into the full queue on the same cycle as a pop.
    send(8'hE0);
    @(negedge clk); ps2_byte = 8'h6B; ps2_byte_valid = 1'b1;
    @(negedge clk); ps2_byte_valid = 1'b0; evt_ready = 1'b1;
    @(negedge clk); evt_ready = 1'b0;
    chk("pushpop_ovf", d_ovf[1], 1'b0);
    chk("pushpop_head", {d_ev_valid[1], d_ev_key[1], d_ev_make[1]}, 4'b1100);
    evt_ready = 1'b1;
    idle(6);
    chk("drained2", d_ev_valid[0], 1'b0);

    // Timeout boundary: 19 quiet cycles keeps E0, 20 abandons it.
    send(8'hE0); idle(18); send(8'h75);
    chk("tmo_edge_hold", d_hold[0], 4'b1100);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); idle(19); send(8'h75);
    chk("tmo_np0_hold", d_hold[0], 4'b1000);
    chk("tmo_np1_hold", d_hold[1], 4'b1100);
    chk("tmo_np1_press", d_press[1], 4'b0100);

    // Non-arrow bytes are dropped.
    send(8'hFA); send(8'hAA); send(8'hE1); send(8'hEE);
    idle(2);

    // Reset in the middle of an extended break.
    send(8'hE0); send(8'hF0);
    #3 reset = 1'b1;
    #1;
    chk("midrst_hold", d_hold[1], 4'b0000);
    chk("midrst_evt_valid", d_ev_valid[1], 1'b0);
    chk("midrst_ovf", d_ovf[1], 1'b0);
    @(negedge clk) reset = 1'b0;
    send(8'h6B);
    chk("post_rst_np1", d_hold[1], 4'b1000);
    chk("post_rst_np1_press", d_press[1], 4'b1000);
    chk("post_rst_np0", d_hold[0], 4'b0000);
    send(8'hE0); send(8'hE0); send(8'h72);
    chk("e0e0_hold", d_hold[0], 4'b0001);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
